sram_arbiter: RTL and testbench

Shares the single 16-bit external SRAM bus (18-bit halfword address, active-low strobes) between the Mips instruction-fetch port and its load/store port. Each granted 32-bit request is split into two big-endian halfword SRAM cycles, and the result is returned with a one-cycle acknowledge. The block sits between the Mips core and the Ram pins, replacing direct core-to-pin wiring.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/sram_io.sv | 52 +++++
 rtl/sram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
// Holds FSM encoding, bus widths and requester port selectors.
package mem_pkg;

    localparam int SRAM_DW = 16;
    localparam int WORD_DW = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        HI_ACC,
        HI_END,
        LO_ACC,
        LO_END,
        ACK
    } state_t;

    typedef struct packed {
        logic wre;
        logic oute;
        logic chip_en;
        logic hb_mask;
        logic lb_mask;
    } strobes_t;

    localparam strobes_t STROBES_OFF = 5'b11111;

    // Writes skip halves whose byte-enable pair is empty.
    function automatic state_t first_state(logic we, logic [3:0] be);
        if (!we || be[3:2] != 2'b00) return HI_ACC;
        if (be[1:0] != 2'b00) return LO_ACC;
        return ACK;
    endfunction

endpackage

// File: rtl/sram_io.sv
// Registered SRAM pin drivers and the data-bus tristate.
// All pin outputs come straight from flops.
module sram_io
    import mem_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               drive_en,
    input  logic [SRAM_DW-1:0] wdata_half,
    input  strobes_t           strobes,
    input  logic               addr_load,
    input  logic [ADDR_W-1:0]  addr_next,
    output logic [ADDR_W-1:0]  addr,
    inout  wire  [SRAM_DW-1:0] data,
    output logic [SRAM_DW-1:0] rdata_half,
    output logic               wre,
    output logic               oute,
    output logic               chip_en,
    output logic               hb_mask,
    output logic               lb_mask
);

    strobes_t           strobes_q;
    logic               drive_q;
    logic [SRAM_DW-1:0] wdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            strobes_q <= STROBES_OFF;
            drive_q   <= 1'b0;
            wdata_q   <= '0;
            addr      <= '0;
        end else begin
            strobes_q <= strobes;
            drive_q   <= drive_en;
            wdata_q   <= wdata_half;
            if (addr_load) addr <= addr_next;
        end
    end

    assign data       = drive_q ? wdata_q : {SRAM_DW{1'bz}};
    assign rdata_half = data;

    assign wre     = strobes_q.wre;
    assign oute    = strobes_q.oute;
    assign chip_en = strobes_q.chip_en;
    assign hb_mask = strobes_q.hb_mask;
    assign lb_mask = strobes_q.lb_mask;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates I-fetch and load/store ports onto one 16-bit SRAM.
// Each 32-bit access is split into big-endian halfword cycles.
module sram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_req,
    input  logic [ADDR_W-2:0]  i_addr,
    output logic               i_ack,
    output logic [WORD_DW-1:0] i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-2:0]  d_addr,
    input  logic [3:0]         d_be,
    input  logic [WORD_DW-1:0] d_wdata,
    output logic               d_ack,
    output logic [WORD_DW-1:0] d_rdata,
    output logic [ADDR_W-1:0]  addr,
    inout  wire  [SRAM_DW-1:0] data,
    output logic               wre,
    output logic               oute,
    output logic               chip_en,
    output logic               hb_mask,
    output logic               lb_mask
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t             state_q, state_d;
    logic               port_q, port_d;
    logic               we_q, we_d;
    logic [ADDR_W-2:0]  waddr_q, waddr_d;
    logic [3:0]         be_q, be_d;
    logic [WORD_DW-1:0] wdata_q, wdata_d;
    logic [2:0]         cnt_q;
    logic [SRAM_DW-1:0] hi_q;

    logic               grant, acc_done;
    logic               hi_half, lo_half, in_acc;
    logic [1:0]         half_be;
    strobes_t           strb;
    logic               drive;
    logic [SRAM_DW-1:0] wdata_half, rdata_half;
    logic [ADDR_W-1:0]  addr_next;

    // Request capture: D has fixed priority, inputs only sampled in IDLE.
    always_comb begin
        grant   = (state_q == IDLE) && (d_req || i_req);
        port_d  = port_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (grant) begin
            port_d  = d_req ? PORT_D : PORT_I;
            we_d    = d_req & d_we;
            waddr_d = d_req ? d_addr : i_addr;
            be_d    = d_req ? d_be : 4'b1111;
            wdata_d = d_wdata;
        end
    end

    always_comb begin
        acc_done = (cnt_q == WS);
        state_d  = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = first_state(we_d, be_d);
            HI_ACC:  if (acc_done) state_d = HI_END;
            HI_END:  state_d = (!we_q || be_q[1:0] != 2'b00) ? LO_ACC : ACK;
            LO_ACC:  if (acc_done) state_d = LO_END;
            LO_END:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values for the coming cycle, registered inside sram_io.
    always_comb begin
        hi_half = (state_d == HI_ACC) || (state_d == HI_END);
        lo_half = (state_d == LO_ACC) || (state_d == LO_END);
        in_acc  = hi_half || lo_half;
        half_be = hi_half ? be_d[3:2] : be_d[1:0];
        strb    = STROBES_OFF;
        drive   = 1'b0;
        if (in_acc) begin
            strb.chip_en = 1'b0;
            strb.oute    = we_d;
            strb.wre     = !(we_d && (state_d == HI_ACC || state_d == LO_ACC));
            strb.hb_mask = we_d & ~half_be[1];
            strb.lb_mask = we_d & ~half_be[0];
            drive        = we_d;
        end
        wdata_half = hi_half ? wdata_d[31:16] : wdata_d[15:0];
        addr_next  = {waddr_d, lo_half};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            port_q  <= PORT_I;
            we_q    <= 1'b0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            if ((state_q == HI_ACC || state_q == LO_ACC) && !acc_done)
                cnt_q <= cnt_q + 3'd1;
            else
                cnt_q <= '0;
        end
    end

    // Read halves are taken on the edge leaving each END state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q    <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (!we_q) begin
            if (state_q == HI_END) hi_q <= rdata_half;
            if (state_q == LO_END) begin
                if (port_q == PORT_D) d_rdata <= {hi_q, rdata_half};
                else                  i_rdata <= {hi_q, rdata_half};
            end
        end
    end

    assign i_ack = (state_q == ACK) && (port_q == PORT_I);
    assign d_ack = (state_q == ACK) && (port_q == PORT_D);

    sram_io #(
        .ADDR_W (ADDR_W)
    ) u_io (
        .clock      (clock),
        .reset      (reset),
        .drive_en   (drive),
        .wdata_half (wdata_half),
        .strobes    (strb),
        .addr_load  (in_acc),
        .addr_next  (addr_next),
        .addr       (addr),
        .data       (data),
        .rdata_half (rdata_half),
        .wre        (wre),
        .oute       (oute),
        .chip_en    (chip_en),
        .hb_mask    (hb_mask),
        .lb_mask    (lb_mask)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter with a behavioural SRAM and
// a word-level reference model; instance 1 uses two wait states.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        i_req   [2];
    logic [16:0] i_addr  [2];
    logic        i_ack   [2];
    logic [31:0] i_rdata [2];
    logic        d_req   [2];
    logic        d_we    [2];
    logic [16:0] d_addr  [2];
    logic [3:0]  d_be    [2];
    logic [31:0] d_wdata [2];
    logic        d_ack   [2];
    logic [31:0] d_rdata [2];
    logic [17:0] addr    [2];
    logic        wre     [2];
    logic        oute    [2];
    logic        chip_en [2];
    logic        hb_mask [2];
    logic        lb_mask [2];
    wire  [15:0] data0, data1;

    logic [15:0] mem     [2][256];
    logic [15:0] ref_mem [2][256];
    bit          mem_init;
    logic [31:0] last_i  [2];
    logic [31:0] last_d  [2];
    int          wcnt    [2];
    int          overlap, ackboth;
    int          n_tests, n_fail;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(18), .WAIT_STATES(0)) dut0 (
        .clock(clk), .reset(rst_n),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_be(d_be[0]),
        .d_wdata(d_wdata[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
        .addr(addr[0]), .data(data0), .wre(wre[0]), .oute(oute[0]),
        .chip_en(chip_en[0]), .hb_mask(hb_mask[0]), .lb_mask(lb_mask[0])
    );

    sram_arbiter #(.ADDR_W(18), .WAIT_STATES(2)) dut1 (
        .clock(clk), .reset(rst_n),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_be(d_be[1]),
        .d_wdata(d_wdata[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
        .addr(addr[1]), .data(data1), .wre(wre[1]), .oute(oute[1]),
        .chip_en(chip_en[1]), .hb_mask(hb_mask[1]), .lb_mask(lb_mask[1])
    );

    function automatic logic [15:0] pat(int a);
        return 16'(a * 16'h1357) ^ 16'hA5C3;
    endfunction

    // Asynchronous-read SRAM model
    assign data0 = (!chip_en[0] && !oute[0]) ? mem[0][addr[0][7:0]] : 16'hzzzz;
    assign data1 = (!chip_en[1] && !oute[1]) ? mem[1][addr[1][7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 256; a++) begin
                mem[0][a] <= pat(a);
                mem[1][a] <= pat(a);
            end
            mem_init <= 1'b1;
        end else begin
            if (!chip_en[0] && !wre[0]) begin
                if (!hb_mask[0]) mem[0][addr[0][7:0]][15:8] <= data0[15:8];
                if (!lb_mask[0]) mem[0][addr[0][7:0]][7:0]  <= data0[7:0];
            end
            if (!chip_en[1] && !wre[1]) begin
                if (!hb_mask[1]) mem[1][addr[1][7:0]][15:8] <= data1[15:8];
                if (!lb_mask[1]) mem[1][addr[1][7:0]][7:0]  <= data1[7:0];
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!wre[k]) wcnt[k]++;
            if (!wre[k] && !oute[k]) overlap++;
            if (i_ack[k] && d_ack[k]) ackboth++;
        end
    end

    function automatic logic [15:0] data_of(int k);
        return (k == 1) ? data1 : data0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs(input int k);
        i_req[k]   = 1'b0;
        i_addr[k]  = '0;
        d_req[k]   = 1'b0;
        d_we[k]    = 1'b0;
        d_addr[k]  = '0;
        d_be[k]    = '0;
        d_wdata[k] = '0;
    endtask

    task automatic ref_write(input int k, input logic [16:0] wa,
                             input logic [3:0] be, input logic [31:0] wd);
        int h;
        h = int'(wa[6:0]) * 2;
        if (be[3]) ref_mem[k][h][15:8]   = wd[31:24];
        if (be[2]) ref_mem[k][h][7:0]    = wd[23:16];
        if (be[1]) ref_mem[k][h+1][15:8] = wd[15:8];
        if (be[0]) ref_mem[k][h+1][7:0]  = wd[7:0];
    endtask

    // Called at a negedge with the DUT idle; returns at a later idle negedge.
    task automatic txn(input int k, input bit is_d, input bit we_in,
                       input logic [16:0] wa, input logic [3:0] be_in,
                       input logic [31:0] wd);
        int ws, halves, lat, n, w0, h;
        bit we, got_i, got_d;
        logic [3:0] be;
        logic [31:0] exp_rd;
        ws = 2 * k;
        we = is_d ? we_in : 1'b0;
        be = is_d ? be_in : 4'hf;
        halves = !we ? 2 : int'(be[3:2] != 2'b00) + int'(be[1:0] != 2'b00);
        lat = 1 + halves * (2 + ws);
        h = int'(wa[6:0]) * 2;
        exp_rd = {ref_mem[k][h], ref_mem[k][h+1]};
        w0 = wcnt[k];
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = wa;
            d_be[k] = be; d_wdata[k] = wd;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = wa;
        end
        n = 0; got_i = 1'b0; got_d = 1'b0;
        while (n < 40 && !got_i && !got_d) begin
            @(negedge clk);
            n++;
            got_i = i_ack[k];
            got_d = d_ack[k];
            if (!got_i && !got_d) begin
                d_we[k]    = 1'($urandom);
                d_addr[k]  = 17'($urandom);
                d_be[k]    = 4'($urandom);
                d_wdata[k] = $urandom;
                i_addr[k]  = 17'($urandom);
            end
        end
        i_req[k] = 1'b0;
        d_req[k] = 1'b0;
        chk("ack_latency", 64'(n), 64'(lat));
        chk("ack_port", {got_i, got_d}, is_d ? 2'b01 : 2'b10);
        if (!we) begin
            if (is_d) last_d[k] = exp_rd;
            else      last_i[k] = exp_rd;
        end else begin
            ref_write(k, wa, be, wd);
        end
        chk("i_rdata", i_rdata[k], last_i[k]);
        chk("d_rdata", d_rdata[k], last_d[k]);
        chk("data_released", data_of(k), 16'hzzzz);
        @(negedge clk);
        chk("ack_pulse", {i_ack[k], d_ack[k]}, 2'b00);
        chk("wre_cycles", 64'(wcnt[k] - w0), we ? 64'(halves * (1 + ws)) : 64'd0);
    endtask

    task automatic chk_reset_pins(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_strobes"},
                {wre[k], oute[k], chip_en[k], hb_mask[k], lb_mask[k]}, 5'b11111);
            chk({tag, "_data_z"}, data_of(k), 16'hzzzz);
            chk({tag, "_addr"}, addr[k], 18'd0);
            chk({tag, "_acks"}, {i_ack[k], d_ack[k]}, 2'b00);
            chk({tag, "_rdata"}, {i_rdata[k], d_rdata[k]}, 64'd0);
        end
    endtask

    initial begin
        int nd, ni, n, errs, k;
        logic [3:0] be;
        n_tests = 0; n_fail = 0; overlap = 0; ackboth = 0;
        for (int j = 0; j < 2; j++) begin
            idle_inputs(j);
            wcnt[j] = 0; last_i[j] = '0; last_d[j] = '0;
            for (int a = 0; a < 256; a++) ref_mem[j][a] = pat(a);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_pins("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word 2 then fetch it back through the I-port
        txn(0, 1, 1, 17'd2, 4'hf, 32'h20020004);
        chk("mem4", mem[0][4], 16'h2002);
        chk("mem5", mem[0][5], 16'h0004);
        txn(0, 0, 0, 17'd2, 4'h0, 32'h0);
        chk("ifetch_word2", i_rdata[0], 32'h20020004);

        txn(0, 1, 1, 17'd8, 4'hf, 32'hDEADBEEF);
        chk("mem16_full", mem[0][16], 16'hDEAD);
        chk("mem17_full", mem[0][17], 16'hBEEF);
        txn(0, 1, 1, 17'd8, 4'b0011, 32'h12345678);
        chk("mem16_keep", mem[0][16], 16'hDEAD);
        chk("mem17_low", mem[0][17], 16'h5678);
        txn(0, 1, 1, 17'd9, 4'b0000, 32'hFFFFFFFF);
        txn(0, 1, 1, 17'd9, 4'b1100, 32'hA1B2C3D4);

        // Simultaneous requests: D first, I six cycles later
        i_req[0] = 1'b1; i_addr[0] = 17'd8;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 17'd2; d_be[0] = 4'hf;
        nd = 0; ni = 0; n = 0;
        while (n < 40 && ni == 0) begin
            @(negedge clk);
            n++;
            if (d_ack[0]) begin nd = n; d_req[0] = 1'b0; end
            if (i_ack[0]) begin ni = n; i_req[0] = 1'b0; end
        end
        chk("prio_d_ack", 64'(nd), 64'd5);
        chk("prio_i_ack", 64'(ni), 64'd11);
        last_d[0] = {ref_mem[0][4], ref_mem[0][5]};
        last_i[0] = {ref_mem[0][16], ref_mem[0][17]};
        chk("prio_d_rdata", d_rdata[0], last_d[0]);
        chk("prio_i_rdata", i_rdata[0], last_i[0]);
        @(negedge clk);

        // Two wait states
        txn(1, 0, 0, 17'd2, 4'h0, 32'h0);
        txn(1, 1, 1, 17'd5, 4'hf, 32'h0BADF00D);
        txn(1, 1, 0, 17'd5, 4'hf, 32'h0);
        chk("ws2_readback", d_rdata[1], 32'h0BADF00D);

        for (int t = 0; t < 80; t++) begin
            k = ($urandom_range(0, 3) == 0) ? 1 : 0;
            be = 4'($urandom);
            if ($urandom_range(0, 5) == 0) be = 4'b0000;
            txn(k, 1'($urandom), 1'($urandom), 17'($urandom_range(0, 127)),
                be, $urandom);
        end

        // Reset during HI_END of a write
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 17'd8;
        d_be[0] = 4'hf; d_wdata[0] = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_pins("midreset");
        idle_inputs(0);
        last_i[0] = '0; last_d[0] = '0; last_i[1] = '0; last_d[1] = '0;
        ref_mem[0][16] = 16'hCAFE;
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (i_ack[0] || d_ack[0]) nd++;
        end
        chk("midreset_no_ack", 64'(nd), 64'd0);
        chk("midreset_mem17", mem[0][17], ref_mem[0][17]);
        txn(0, 1, 0, 17'd8, 4'hf, 32'h0);

        for (int j = 0; j < 2; j++) begin
            errs = 0;
            for (int a = 0; a < 256; a++)
                if (mem[j][a] !== ref_mem[j][a]) errs++;
            chk("mem_final", 64'(errs), 64'd0);
        end
        chk("wre_oute_overlap", 64'(overlap), 64'd0);
        chk("ack_overlap", 64'(ackboth), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
